// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the instruction-fetch slice:
//   - state_t      : fetch sequencer states (boot load, run, halt)
//   - NOP_INST     : instruction handed to the core when nothing is fetched
//   - WORD_BYTES   : byte stride of one instruction word
//   - ERR_*        : sticky fault codes reported on ERR
// ----------------------------------------------------------------------------
package rv_pkg;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;   // addi x0, x0, 0
   localparam logic [31:0] WORD_BYTES = 32'd4;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the loader stream, core control, instruction-memory port and core
// instruction delivery of the fetch controller.
//   master : the fetch controller (drives LD_READY, MEM_*, PC, INST_*, status)
//   slave  : the surroundings (loader, core, memory)
// ----------------------------------------------------------------------------
interface imem_fetch_ctrl_if;

   // loader stream
   logic        LD_VALID;
   logic [31:0] LD_DATA;
   logic        LD_LAST;
   logic        LD_READY;
   // core control
   logic        STALL;
   logic        BR_TAKEN;
   logic [31:0] BR_TARGET;
   // instruction memory port
   logic [31:0] MEM_ADDR;
   logic        MEM_WE;
   logic [31:0] MEM_WDATA;
   logic [31:0] MEM_RDATA;
   // delivery and status
   logic [31:0] PC;
   logic [31:0] INST_CODE;
   logic        INST_VALID;
   logic        LOAD_DONE;
   logic [1:0]  ERR;

   modport master (
      input  LD_VALID, LD_DATA, LD_LAST, STALL, BR_TAKEN, BR_TARGET, MEM_RDATA,
      output LD_READY, MEM_ADDR, MEM_WE, MEM_WDATA, PC, INST_CODE, INST_VALID,
             LOAD_DONE, ERR
   );

   modport slave (
      output LD_VALID, LD_DATA, LD_LAST, STALL, BR_TAKEN, BR_TARGET, MEM_RDATA,
      input  LD_READY, MEM_ADDR, MEM_WE, MEM_WDATA, PC, INST_CODE, INST_VALID,
             LOAD_DONE, ERR
   );

endinterface

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection with fault detection.
//   pc, stall, br_taken, br_target : current PC and core requests
//   pc_next                        : PC to load (equals pc when faulting)
//   fault, fault_code              : candidate rejected and why
// Priority: redirect > stall > sequential. A redirect to a non-word-aligned
// target is a misalignment fault; any candidate at or beyond the memory end
// is a range fault.
// ----------------------------------------------------------------------------
module pc_next_sel
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] pc_next,
   output logic        fault,
   output logic [1:0]  fault_code
);

   // Compared in 33 bits so a wrap of pc+4 past 2^32 still reads as out of range.
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

   logic [32:0] cand;

   always_comb begin
      cand       = {1'b0, pc} + {1'b0, WORD_BYTES};
      fault      = 1'b0;
      fault_code = ERR_NONE;
      if (br_taken) begin
         cand = {1'b0, br_target};
      end else if (stall) begin
         cand = {1'b0, pc};
      end
      if (br_taken && (br_target[1:0] != 2'b00)) begin
         fault      = 1'b1;
         fault_code = ERR_MISALIGN;
      end else if (cand >= LIMIT) begin
         fault      = 1'b1;
         fault_code = ERR_RANGE;
      end
      pc_next = fault ? pc : cand[31:0];
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Owns the instruction-memory port and the architectural PC. After reset it
// accepts a boot-load stream and writes it sequentially into memory, then
// fetches one instruction per cycle (zero-cycle PC->INST_CODE latency),
// honouring stall and redirect, and halts on a fetch fault until reset.
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : loader stream, core control, memory port, delivery and status
// ----------------------------------------------------------------------------
module imem_fetch_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RESET,
   imem_fetch_ctrl_if.master bus
);

   localparam logic [31:0] LAST_SLOT = 32'((DEPTH_WORDS - 1) * 4);

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] load_ptr, load_ptr_nxt;
   logic        load_done, load_done_nxt;
   logic [1:0]  err, err_nxt;

   logic [31:0] sel_pc;
   logic        sel_fault;
   logic [1:0]  sel_code;

   logic        ld_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] inst_code;
   logic        inst_valid;

   pc_next_sel #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_pc_next_sel (
      .pc         (pc),
      .stall      (bus.STALL),
      .br_taken   (bus.BR_TAKEN),
      .br_target  (bus.BR_TARGET),
      .pc_next    (sel_pc),
      .fault      (sel_fault),
      .fault_code (sel_code)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= S_LOAD;
         pc        <= RESET_PC;
         load_ptr  <= '0;
         load_done <= 1'b0;
         err       <= ERR_NONE;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         load_ptr  <= load_ptr_nxt;
         load_done <= load_done_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      load_ptr_nxt  = load_ptr;
      load_done_nxt = load_done;
      err_nxt       = err;
      ld_ready      = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = pc;
      inst_code     = NOP_INST;
      inst_valid    = 1'b0;

      case (state)
         S_LOAD: begin
            ld_ready = 1'b1;
            mem_addr = load_ptr;
            mem_we   = bus.LD_VALID;
            if (bus.LD_VALID) begin
               load_ptr_nxt = load_ptr + WORD_BYTES;
               // Filling the last slot ends the load even without LD_LAST.
               if (bus.LD_LAST || (load_ptr == LAST_SLOT)) begin
                  state_nxt     = S_RUN;
                  load_done_nxt = 1'b1;
                  pc_nxt        = RESET_PC;
               end
            end
         end
         S_RUN: begin
            inst_code  = bus.MEM_RDATA;
            inst_valid = 1'b1;
            if (sel_fault) begin
               state_nxt = S_HALT;
               err_nxt   = sel_code;
            end else begin
               pc_nxt = sel_pc;
            end
         end
         default: begin
            state_nxt = S_HALT;
         end
      endcase

      // Handshake and write strobes are forced quiet while reset is held,
      // not just from the first edge after it.
      if (!RESET) begin
         ld_ready   = 1'b0;
         mem_we     = 1'b0;
         inst_valid = 1'b0;
         inst_code  = NOP_INST;
      end
   end

   assign bus.LD_READY   = ld_ready;
   assign bus.MEM_WE     = mem_we;
   assign bus.MEM_ADDR   = mem_addr;
   assign bus.MEM_WDATA  = bus.LD_DATA;
   assign bus.PC         = pc;
   assign bus.INST_CODE  = inst_code;
   assign bus.INST_VALID = inst_valid;
   assign bus.LOAD_DONE  = load_done;
   assign bus.ERR        = err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl. Two instances: a 256-word one for load,
// stall, redirect, misalignment and mid-load reset, and a 4-word one for load
// overflow and the fetch range fault. Each has a small memory model.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl_if bus_a ();
   imem_fetch_ctrl_if bus_b ();

   imem_fetch_ctrl #(
      .DEPTH_WORDS (256),
      .RESET_PC    (32'h0000_0000)
   ) u_dut_a (
      .CLK   (clk),
      .RESET (rst_a),
      .bus   (bus_a)
   );

   imem_fetch_ctrl #(
      .DEPTH_WORDS (4),
      .RESET_PC    (32'h0000_0000)
   ) u_dut_b (
      .CLK   (clk),
      .RESET (rst_b),
      .bus   (bus_b)
   );

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [4];
   int          wr_b = 0;

   always @(posedge clk) begin
      if (bus_a.MEM_WE) mem_a[bus_a.MEM_ADDR[9:2]] <= bus_a.MEM_WDATA;
      if (bus_b.MEM_WE) begin
         wr_b <= wr_b + 1;
         if (bus_b.MEM_ADDR < 32'd16) mem_b[bus_b.MEM_ADDR[3:2]] <= bus_b.MEM_WDATA;
      end
   end

   assign bus_a.MEM_RDATA = mem_a[bus_a.MEM_ADDR[9:2]];
   assign bus_b.MEM_RDATA = (bus_b.MEM_ADDR < 32'd16) ? mem_b[bus_b.MEM_ADDR[3:2]]
                                                      : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a           = 1'b0;
      rst_b           = 1'b0;
      bus_a.LD_VALID  = 1'b1;
      bus_a.LD_DATA   = 32'h1234_5678;
      bus_a.LD_LAST   = 1'b0;
      bus_a.STALL     = 1'b0;
      bus_a.BR_TAKEN  = 1'b0;
      bus_a.BR_TARGET = 32'h0;
      bus_b.LD_VALID  = 1'b0;
      bus_b.LD_DATA   = 32'h0;
      bus_b.LD_LAST   = 1'b0;
      bus_b.STALL     = 1'b0;
      bus_b.BR_TAKEN  = 1'b0;
      bus_b.BR_TARGET = 32'h0;
      #2;

      // reset values, with a loader word already offered
      chk("rst_pc",        bus_a.PC,               32'h0);
      chk("rst_ld_ready",  32'(bus_a.LD_READY),    32'd0);
      chk("rst_mem_we",    32'(bus_a.MEM_WE),      32'd0);
      chk("rst_inst_vld",  32'(bus_a.INST_VALID),  32'd0);
      chk("rst_inst_code", bus_a.INST_CODE,        32'h0000_0013);
      chk("rst_load_done", 32'(bus_a.LOAD_DONE),   32'd0);
      chk("rst_err",       32'(bus_a.ERR),         32'd0);
      tick();
      tick();
      rst_a = 1'b1;
      rst_b = 1'b1;

      // boot load of three words, LAST on the third
      bus_a.LD_DATA = 32'h0050_0093;
      #1;
      chk("ld0_ready", 32'(bus_a.LD_READY), 32'd1);
      chk("ld0_we",    32'(bus_a.MEM_WE),   32'd1);
      chk("ld0_addr",  bus_a.MEM_ADDR,      32'h0);
      chk("ld0_inst",  bus_a.INST_CODE,     32'h0000_0013);
      tick();
      bus_a.LD_DATA = 32'h00A0_0113;
      #1;
      chk("ld1_we",   32'(bus_a.MEM_WE), 32'd1);
      chk("ld1_addr", bus_a.MEM_ADDR,    32'h4);
      tick();
      bus_a.LD_DATA = 32'h0020_81B3;
      bus_a.LD_LAST = 1'b1;
      #1;
      chk("ld2_we",   32'(bus_a.MEM_WE),    32'd1);
      chk("ld2_addr", bus_a.MEM_ADDR,       32'h8);
      chk("ld2_done", 32'(bus_a.LOAD_DONE), 32'd0);
      tick();
      bus_a.LD_VALID = 1'b0;
      bus_a.LD_LAST  = 1'b0;
      #1;
      chk("run_done",     32'(bus_a.LOAD_DONE),  32'd1);
      chk("run_pc0",      bus_a.PC,              32'h0);
      chk("run_inst0",    bus_a.INST_CODE,       32'h0050_0093);
      chk("run_vld0",     32'(bus_a.INST_VALID), 32'd1);
      chk("run_ld_ready", 32'(bus_a.LD_READY),   32'd0);
      chk("mem_a2",       mem_a[2],              32'h0020_81B3);
      tick();
      chk("run_pc4",   bus_a.PC,        32'h4);
      chk("run_inst1", bus_a.INST_CODE, 32'h00A0_0113);
      tick();
      chk("run_pc8",   bus_a.PC,        32'h8);
      chk("run_inst2", bus_a.INST_CODE, 32'h0020_81B3);

      // stall for three cycles at PC=8
      bus_a.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc",   bus_a.PC,              32'h8);
         chk("stall_inst", bus_a.INST_CODE,       32'h0020_81B3);
         chk("stall_vld",  32'(bus_a.INST_VALID), 32'd1);
      end
      bus_a.STALL = 1'b0;
      tick();
      chk("unstall_pc", bus_a.PC, 32'hC);

      // redirect wins over a simultaneous stall
      bus_a.BR_TAKEN  = 1'b1;
      bus_a.BR_TARGET = 32'h20;
      bus_a.STALL     = 1'b1;
      tick();
      bus_a.BR_TAKEN = 1'b0;
      bus_a.STALL    = 1'b0;
      chk("br_pc",  bus_a.PC,         32'h20);
      chk("br_err", 32'(bus_a.ERR),   32'd0);

      // misaligned redirect halts with ERR=1
      bus_a.BR_TAKEN  = 1'b1;
      bus_a.BR_TARGET = 32'h22;
      tick();
      bus_a.BR_TAKEN = 1'b0;
      bus_a.LD_VALID = 1'b1;
      #1;
      chk("mis_err",      32'(bus_a.ERR),        32'd1);
      chk("mis_pc",       bus_a.PC,              32'h20);
      chk("mis_vld",      32'(bus_a.INST_VALID), 32'd0);
      chk("mis_inst",     bus_a.INST_CODE,       32'h0000_0013);
      chk("halt_ready",   32'(bus_a.LD_READY),   32'd0);
      chk("halt_we",      32'(bus_a.MEM_WE),     32'd0);
      tick();
      tick();
      chk("halt_pc",  bus_a.PC,         32'h20);
      chk("halt_err", 32'(bus_a.ERR),   32'd1);
      bus_a.LD_VALID = 1'b0;

      // reset clears the halt
      rst_a = 1'b0;
      #1;
      chk("clr_err",  32'(bus_a.ERR),       32'd0);
      chk("clr_done", 32'(bus_a.LOAD_DONE), 32'd0);
      chk("clr_pc",   bus_a.PC,             32'h0);
      tick();
      rst_a = 1'b1;

      // reset after two of four load words, then reload from address 0
      bus_a.LD_VALID = 1'b1;
      bus_a.LD_DATA  = 32'h1111_0000;
      tick();
      bus_a.LD_DATA = 32'h1111_0004;
      tick();
      chk("mid_addr", bus_a.MEM_ADDR, 32'h8);
      rst_a = 1'b0;
      #1;
      chk("mid_ready", 32'(bus_a.LD_READY), 32'd0);
      chk("mid_we",    32'(bus_a.MEM_WE),   32'd0);
      chk("mid_ptr",   bus_a.MEM_ADDR,      32'h0);
      chk("mid_inst",  bus_a.INST_CODE,     32'h0000_0013);
      tick();
      rst_a         = 1'b1;
      bus_a.LD_DATA = 32'hAAAA_0001;
      #1;
      chk("rl_addr", bus_a.MEM_ADDR,    32'h0);
      chk("rl_we",   32'(bus_a.MEM_WE), 32'd1);
      tick();
      bus_a.LD_VALID = 1'b0;
      chk("rl_mem0", mem_a[0], 32'hAAAA_0001);
      chk("rl_mem1", mem_a[1], 32'h1111_0004);

      // 4-word instance: six words without LAST, only four accepted
      bus_b.LD_VALID = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus_b.LD_DATA = 32'hB0 + 32'(i);
         #1;
         if (i < 4) begin
            chk("ovf_we",   32'(bus_b.MEM_WE),   32'd1);
            chk("ovf_addr", bus_b.MEM_ADDR,      32'(4 * i));
         end else begin
            chk("ovf_ready", 32'(bus_b.LD_READY), 32'd0);
            chk("ovf_nowe",  32'(bus_b.MEM_WE),   32'd0);
         end
         if (i == 4) chk("ovf_inst0", bus_b.INST_CODE, 32'hB0);
         tick();
      end
      bus_b.LD_VALID = 1'b0;
      chk("ovf_wr_cnt", 32'(wr_b),  32'd4);
      chk("ovf_mem3",   mem_b[3],   32'hB3);
      chk("rng_pc8",    bus_b.PC,   32'h8);
      tick();
      chk("rng_pc12",   bus_b.PC,              32'hC);
      chk("rng_inst3",  bus_b.INST_CODE,       32'hB3);
      chk("rng_vld",    32'(bus_b.INST_VALID), 32'd1);
      tick();
      chk("rng_err",    32'(bus_b.ERR),        32'd2);
      chk("rng_hold",   bus_b.PC,              32'hC);
      chk("rng_novld",  32'(bus_b.INST_VALID), 32'd0);
      chk("rng_nop",    bus_b.INST_CODE,       32'h0000_0013);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
